store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 26 ++
 rtl/store_buffer_if.sv | 40 ++++
 rtl/sb_fifo.sv | 67 ++++++
 rtl/store_buffer.sv | 86 ++++++++
 tb/tb_store_buffer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sb_pkg
// Description : Shared types and defaults for the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;
  localparam int SB_DEPTH      = 4;
  localparam int SB_WIDTH      = 32;
  localparam int SB_ADDR_LINES = 32;

  // Occupancy-derived buffer state
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } sb_state_t;

  // One buffered store: word address plus data
  typedef struct packed {
    logic [SB_ADDR_LINES-3:0] waddr;
    logic [SB_WIDTH-1:0]      data;
  } sb_entry_t;
endpackage
`default_nettype wire

// File: rtl/store_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_buffer_if
// Description : Core store/load port and data-memory port of the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int width         = SB_WIDTH,
  parameter int address_lines = SB_ADDR_LINES
);
  logic                     st_valid;
  logic [address_lines-1:0] st_addr;
  logic [width-1:0]         st_data;
  logic                     st_ready;
  logic                     st_misalign;
  logic                     ld_valid;
  logic [address_lines-1:0] ld_addr;
  logic [width-1:0]         ld_data;
  logic                     ld_stall;
  logic                     mem_WE;
  logic [address_lines-1:0] mem_A;
  logic [width-1:0]         mem_WD;
  logic [width-1:0]         mem_RD;

  // Core and memory environment side
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_RD,
    input  st_ready, st_misalign, ld_data, ld_stall, mem_WE, mem_A, mem_WD
  );

  // Store buffer side
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_RD,
    output st_ready, st_misalign, ld_data, ld_stall, mem_WE, mem_A, mem_WD
  );
endinterface
`default_nettype wire

// File: rtl/sb_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sb_fifo
// Description : Circular store storage with head/tail/count and a
//               youngest-match lookup used for load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fifo
  import sb_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
)(
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire sb_entry_t                push_entry,
  input  wire logic                     pop,
  output sb_entry_t                     head_entry,
  output logic [CW-1:0]                 count,
  input  wire logic [SB_ADDR_LINES-3:0] lookup_waddr,
  output logic                          hit,
  output logic [SB_WIDTH-1:0]           hit_data
);
  sb_entry_t       entries [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  // Entry payload is never reset; only entries within count are considered live
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= push_entry;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_entry = entries[head];

  // Walk oldest to youngest so the last match found is the youngest store;
  // the head entry counts as live even on the edge it retires
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (entries[idx].waddr == lookup_waddr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Word store buffer between core and data memory: occupancy
//               FSM, memory-port arbitration, drain and load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
  import sb_pkg::*;
#(
  parameter  int DEPTH         = SB_DEPTH,
  parameter  int width         = SB_WIDTH,
  parameter  int address_lines = SB_ADDR_LINES,
  localparam int CW            = $clog2(DEPTH) + 1
)(
  input  wire logic     clk,
  input  wire logic     rst_n,
  store_buffer_if.slave bus,
  output logic          empty
);
  sb_state_t         state;
  sb_state_t         state_next;
  logic              push;
  logic              drain;
  logic              port_free;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  sb_entry_t         push_entry;
  sb_entry_t         head_entry;
  logic              hit;
  logic [width-1:0]  hit_data;
  logic              unused_ld_lsb;

  assign push_entry.waddr = bus.st_addr[address_lines-1:2];
  assign push_entry.data  = bus.st_data;
  assign unused_ld_lsb    = ^bus.ld_addr[1:0];

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (drain),
    .head_entry   (head_entry),
    .count        (count),
    .lookup_waddr (bus.ld_addr[address_lines-1:2]),
    .hit          (hit),
    .hit_data     (hit_data)
  );

  // State register; reset forces EMPTY so no write can issue during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Handshake, arbitration, memory mux and next state derived from count
  always_comb begin
    bus.st_misalign = bus.st_valid & (bus.st_addr[1:0] != 2'b00);
    bus.st_ready    = (state != FULL);
    bus.ld_stall    = bus.ld_valid & (state == FULL);
    port_free       = ~bus.ld_valid | bus.ld_stall;
    drain           = (state != EMPTY) & port_free;
    push            = bus.st_valid & bus.st_ready & ~bus.st_misalign;
    count_next      = count + CW'(push) - CW'(drain);
    bus.mem_WE      = drain;
    bus.mem_A       = '0;
    bus.mem_WD      = '0;
    bus.ld_data     = (bus.ld_valid & hit) ? hit_data : bus.mem_RD;
    empty           = (state == EMPTY);
    state_next      = state;

    if (drain) begin
      bus.mem_A  = {2'b00, head_entry.waddr};
      bus.mem_WD = head_entry.data;
    end else if (bus.ld_valid) begin
      bus.mem_A  = {2'b00, bus.ld_addr[address_lines-1:2]};
    end

    if (count_next == '0)              state_next = EMPTY;
    else if (count_next == CW'(DEPTH)) state_next = FULL;
    else                               state_next = ACTIVE;
  end
endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  import sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        empty;
  logic        mem_loaded = 1'b0;
  logic        excl_on = 1'b1;
  logic [31:0] mem_model [0:63];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  logic [31:0] sb_a, sb_d;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb_if),
    .empty (empty)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Memory model: asynchronous read, synchronous write
  assign sb_if.mem_RD = mem_model[sb_if.mem_A[5:0]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (rst_n && sb_if.mem_WE) begin
      mem_model[sb_if.mem_A[5:0]] <= sb_if.mem_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every memory write must match the oldest expected store
  always @(negedge clk) begin
    if (rst_n && sb_if.mem_WE) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write observed=0x%08h expected=none", sb_if.mem_A);
      end else begin
        sb_a = exp_a.pop_front();
        sb_d = exp_d.pop_front();
        chk("sb_mem_A", sb_if.mem_A, sb_a);
        chk("sb_mem_WD", sb_if.mem_WD, sb_d);
      end
    end
    if (excl_on && rst_n) begin
      assert (!(sb_if.st_valid && sb_if.ld_valid)) else begin
        bad++;
        $error("FAIL excl observed=both expected=one");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_data  = '0;
    sb_if.ld_valid = 1'b0;
    sb_if.ld_addr  = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_data  = d;
  endtask

  task automatic load(input logic [31:0] a);
    sb_if.ld_valid = 1'b1;
    sb_if.ld_addr  = a;
  endtask

  task automatic expect_write(input logic [31:0] widx, input logic [31:0] d);
    exp_a.push_back(widx);
    exp_d.push_back(d);
  endtask

  task automatic wait_empty(input string tag);
    for (int n = 0; n < 50 && empty !== 1'b1; n++) step();
    chk(tag, 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(sb_if.st_ready), 32'd1);
    chk("rst_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    chk("rst_ld_stall", 32'(sb_if.ld_stall), 32'd0);
    chk("rst_mem_A", sb_if.mem_A, 32'd0);
    chk("rst_mem_WD", sb_if.mem_WD, 32'd0);
    chk("rst_ld_data", sb_if.ld_data, init_val(0));
    rst_n = 1'b1;

    // Single store drains the following cycle
    step();
    store(32'h10, 32'hDEADBEEF);
    expect_write(32'h4, 32'hDEADBEEF);
    #1;
    chk("st1_ready", 32'(sb_if.st_ready), 32'd1);
    chk("st1_misalign", 32'(sb_if.st_misalign), 32'd0);
    chk("st1_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    step();
    idle();
    #1;
    chk("drain1_mem_WE", 32'(sb_if.mem_WE), 32'd1);
    chk("drain1_mem_A", sb_if.mem_A, 32'h4);
    chk("drain1_mem_WD", sb_if.mem_WD, 32'hDEADBEEF);
    step();
    #1;
    chk("drain1_empty", 32'(empty), 32'd1);
    chk("drain1_mem", mem_model[4], 32'hDEADBEEF);

    // Youngest-match forwarding
    step();
    store(32'h20, 32'h1);
    expect_write(32'h8, 32'h1);
    step();
    store(32'h20, 32'h2);
    expect_write(32'h8, 32'h2);
    step();
    idle();
    load(32'h20);
    #1;
    chk("fwd_ld_data", sb_if.ld_data, 32'h2);
    chk("fwd_ld_stall", 32'(sb_if.ld_stall), 32'd0);
    chk("fwd_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    chk("fwd_mem_A", sb_if.mem_A, 32'h8);
    step();
    idle();
    wait_empty("fwd_empty");
    chk("fwd_mem", mem_model[8], 32'h2);

    // Misaligned store is rejected
    step();
    store(32'h13, 32'hBAD0BAD0);
    #1;
    chk("mis_flag", 32'(sb_if.st_misalign), 32'd1);
    chk("mis_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    step();
    idle();
    #1;
    chk("mis_empty", 32'(empty), 32'd1);
    chk("mis_mem_WE2", 32'(sb_if.mem_WE), 32'd0);
    chk("mis_mem", mem_model[4], 32'hDEADBEEF);
    chk("mis_idle_flag", 32'(sb_if.st_misalign), 32'd0);

    // Fill to FULL while a load holds the port, then stall and drain
    excl_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      store(32'h40 + 32'(4 * i), 32'h100 + 32'(i));
      load(32'h40);
      expect_write(32'd16 + 32'(i), 32'h100 + 32'(i));
      #1;
      chk("fill_st_ready", 32'(sb_if.st_ready), 32'd1);
      chk("fill_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    end
    step();
    store(32'h50, 32'h104);
    load(32'h40);
    #1;
    chk("full_st_ready", 32'(sb_if.st_ready), 32'd0);
    chk("full_ld_stall", 32'(sb_if.ld_stall), 32'd1);
    chk("full_mem_WE", 32'(sb_if.mem_WE), 32'd1);
    chk("full_mem_A", sb_if.mem_A, 32'h10);
    chk("full_mem_WD", sb_if.mem_WD, 32'h100);
    chk("full_ld_data", sb_if.ld_data, 32'h100);
    step();
    expect_write(32'd20, 32'h104);
    #1;
    chk("served_ld_stall", 32'(sb_if.ld_stall), 32'd0);
    chk("served_st_ready", 32'(sb_if.st_ready), 32'd1);
    chk("served_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    chk("served_mem_A", sb_if.mem_A, 32'h10);
    chk("served_ld_data", sb_if.ld_data, 32'h100);
    step();
    idle();
    excl_on = 1'b1;
    wait_empty("full_empty");
    for (int i = 0; i < 5; i++) chk("full_mem", mem_model[16 + i], 32'h100 + 32'(i));

    // Ten stores with interleaved loads; pointers wrap
    for (int i = 0; i < 10; i++) begin
      step();
      idle();
      store(32'(4 * i), 32'h1000 + 32'(i));
      expect_write(32'(i), 32'h1000 + 32'(i));
      #1;
      chk("wrap_st_ready", 32'(sb_if.st_ready), 32'd1);
      if (i % 2 == 1) begin
        step();
        idle();
        load(32'(4 * i));
        #1;
        chk("wrap_ld_data", sb_if.ld_data, 32'h1000 + 32'(i));
      end
    end
    step();
    idle();
    wait_empty("wrap_empty");
    for (int i = 0; i < 10; i++) chk("wrap_mem", mem_model[i], 32'h1000 + 32'(i));

    // Reset with three stores pending discards them
    excl_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      store(32'h80 + 32'(4 * i), 32'h2000 + 32'(i));
      load(32'hF0);
    end
    step();
    idle();
    rst_n = 1'b0;
    exp_a.delete();
    exp_d.delete();
    #1;
    chk("rst2_mem_WE", 32'(sb_if.mem_WE), 32'd0);
    chk("rst2_empty", 32'(empty), 32'd1);
    chk("rst2_st_ready", 32'(sb_if.st_ready), 32'd1);
    chk("rst2_ld_stall", 32'(sb_if.ld_stall), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    excl_on = 1'b1;
    repeat (3) step();
    chk("rst2_empty_after", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) chk("rst2_mem", mem_model[32 + i], init_val(32 + i));

    chk("sb_left", 32'(exp_a.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
